// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: alignment check, sram-like data port handshake, load extension.
// Optional watchdog in WAIT is enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [7:0]  ex_alucontrol,
    input  logic [31:0] ex_aluout,
    input  logic [31:0] ex_rt_data,
    input  logic        flush,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        mem_stall,
    output logic        mem_valid,
    output logic [31:0] mem_rdata,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic [31:0] exc_badvaddr
);
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;

    state_t     state_r;
    logic [7:0] op_r;
    logic       discard_r;
    logic       is_load_s, is_store_s, misaligned_s, start_s, drop_s;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 256) ? $clog2(TIMEOUT_CYCLES) : 8;
    logic [CNT_W-1:0] cnt_r;
`endif

    function automatic logic [1:0] op_size(input logic [7:0] op);
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: op_size = 2'd1;
            EXE_LW_OP, EXE_SW_OP:             op_size = 2'd2;
            default:                          op_size = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] op_wstrb(input logic [7:0] op, input logic [1:0] a);
        case (op)
            EXE_SB_OP: op_wstrb = 4'b0001 << a;
            EXE_SH_OP: op_wstrb = a[1] ? 4'b1100 : 4'b0011;
            EXE_SW_OP: op_wstrb = 4'b1111;
            default:   op_wstrb = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] op_wdata(input logic [7:0] op, input logic [31:0] rt);
        case (op)
            EXE_SB_OP: op_wdata = {4{rt[7:0]}};
            EXE_SH_OP: op_wdata = {2{rt[15:0]}};
            EXE_SW_OP: op_wdata = rt;
            default:   op_wdata = 32'h0000_0000;
        endcase
    endfunction

    // Stores complete with zero; loads select the addressed byte/half and extend it.
    function automatic logic [31:0] load_extend(input logic [7:0] op, input logic [1:0] a,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (op)
            EXE_LB_OP:  load_extend = {{24{b[7]}}, b};
            EXE_LBU_OP: load_extend = {24'h00_0000, b};
            EXE_LH_OP:  load_extend = {{16{h[15]}}, h};
            EXE_LHU_OP: load_extend = {16'h0000, h};
            EXE_LW_OP:  load_extend = rd;
            default:    load_extend = 32'h0000_0000;
        endcase
    endfunction

    // Opcode decode, alignment check and start qualification.
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        case (ex_alucontrol)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: is_load_s = 1'b1;
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP:                         is_store_s = 1'b1;
            default: begin
                is_load_s  = 1'b0;
                is_store_s = 1'b0;
            end
        endcase
        case (op_size(ex_alucontrol))
            2'd1:    misaligned_s = ex_aluout[0];
            2'd2:    misaligned_s = |ex_aluout[1:0];
            default: misaligned_s = 1'b0;
        endcase
        start_s = ex_valid & (is_load_s | is_store_s) & (state_r == S_IDLE) & ~flush & ~rst;
        drop_s  = discard_r | flush;
    end

    // A discarded access no longer holds the pipeline.
    assign mem_stall = start_s | (((state_r == S_REQ) | (state_r == S_WAIT)) & ~discard_r);

    // Access FSM with registered port, result and exception outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            op_r         <= 8'h00;
            discard_r    <= 1'b0;
            data_req     <= 1'b0;
            data_wr      <= 1'b0;
            data_size    <= 2'd0;
            data_addr    <= 32'h0000_0000;
            data_wstrb   <= 4'b0000;
            data_wdata   <= 32'h0000_0000;
            mem_valid    <= 1'b0;
            mem_rdata    <= 32'h0000_0000;
            exc_adel     <= 1'b0;
            exc_ades     <= 1'b0;
            exc_badvaddr <= 32'h0000_0000;
`ifdef MEM_TIMEOUT_EN
            cnt_r        <= {CNT_W{1'b0}};
`endif
        end else begin
            mem_valid <= 1'b0;
            exc_adel  <= 1'b0;
            exc_ades  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start_s && misaligned_s) begin
                        exc_adel     <= is_load_s;
                        exc_ades     <= is_store_s;
                        exc_badvaddr <= ex_aluout;
                    end else if (start_s) begin
                        state_r    <= S_REQ;
                        op_r       <= ex_alucontrol;
                        discard_r  <= 1'b0;
                        data_req   <= 1'b1;
                        data_wr    <= is_store_s;
                        data_size  <= op_size(ex_alucontrol);
                        data_addr  <= ex_aluout;
                        data_wstrb <= op_wstrb(ex_alucontrol, ex_aluout[1:0]);
                        data_wdata <= op_wdata(ex_alucontrol, ex_rt_data);
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (data_addr_ok) begin
                        // Once accepted, the access must run to completion even if flushed.
                        data_req  <= 1'b0;
                        discard_r <= flush;
`ifdef MEM_TIMEOUT_EN
                        cnt_r     <= {CNT_W{1'b0}};
`endif
                        if (data_data_ok) begin
                            state_r   <= S_DONE;
                            mem_valid <= ~flush;
                            mem_rdata <= load_extend(op_r, data_addr[1:0], data_rdata);
                        end else begin
                            state_r <= S_WAIT;
                        end
                    end else if (flush) begin
                        data_req <= 1'b0;
                        state_r  <= S_IDLE;
                    end else begin
                        state_r <= S_REQ;
                    end
                end
                S_WAIT: begin
                    discard_r <= drop_s;
                    if (data_data_ok) begin
                        state_r   <= S_DONE;
                        mem_valid <= ~drop_s;
                        mem_rdata <= load_extend(op_r, data_addr[1:0], data_rdata);
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_r   <= S_IDLE;
                        discard_r <= 1'b0;
                        mem_valid <= ~drop_s;
                        mem_rdata <= 32'hdead_beef;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
`else
                    else begin
                        state_r <= S_WAIT;
                    end
`endif
                end
                S_DONE: begin
                    state_r   <= S_IDLE;
                    discard_r <= 1'b0;
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (loads, stores, alignment, flush, reset).
module tb_mem_access_unit;
    localparam logic [7:0] LB  = 8'b1110_0000;
    localparam logic [7:0] LH  = 8'b1110_0001;
    localparam logic [7:0] LW  = 8'b1110_0011;
    localparam logic [7:0] LBU = 8'b1110_0100;
    localparam logic [7:0] LHU = 8'b1110_0101;
    localparam logic [7:0] SB  = 8'b1110_1000;
    localparam logic [7:0] SH  = 8'b1110_1001;
    localparam logic [7:0] SW  = 8'b1110_1011;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [7:0]  ex_alucontrol;
    logic [31:0] ex_aluout, ex_rt_data;
    logic        flush;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_stall, mem_valid;
    logic [31:0] mem_rdata;
    logic        exc_adel, exc_ades;
    logic [31:0] exc_badvaddr;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alucontrol(ex_alucontrol),
        .ex_aluout(ex_aluout), .ex_rt_data(ex_rt_data), .flush(flush),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .mem_stall(mem_stall),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata), .exc_adel(exc_adel),
        .exc_ades(exc_ades), .exc_badvaddr(exc_badvaddr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt);
        ex_valid = 1'b1; ex_alucontrol = op; ex_aluout = addr; ex_rt_data = rt;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_alucontrol = 8'h00; ex_aluout = 32'h0; ex_rt_data = 32'h0;
    endtask

    // Full access: start, aw cycles without addr_ok, addr_ok, data_ok, then the result cycle.
    task automatic access(input string tag, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] rt, input int aw, input logic [31:0] rdata,
                          input logic [31:0] exp_rd, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wd, input logic [1:0] exp_size, input logic exp_wr);
        start(op, addr, rt); #1;
        check({tag, " stall_c0"}, 32'(mem_stall), 32'd1);
        check({tag, " req_c0"}, 32'(data_req), 32'd0);
        step(); idle_inputs();
        for (int i = 0; i < aw; i++) begin
            #1;
            check({tag, " req_hold"}, 32'(data_req), 32'd1);
            check({tag, " addr_hold"}, data_addr, addr);
            check({tag, " wdata_hold"}, data_wdata, exp_wd);
            step();
        end
        data_addr_ok = 1'b1; #1;
        check({tag, " req"}, 32'(data_req), 32'd1);
        check({tag, " addr"}, data_addr, addr);
        check({tag, " size"}, 32'(data_size), 32'(exp_size));
        check({tag, " wr"}, 32'(data_wr), 32'(exp_wr));
        check({tag, " wstrb"}, 32'(data_wstrb), 32'(exp_strb));
        check({tag, " wdata"}, data_wdata, exp_wd);
        check({tag, " stall_req"}, 32'(mem_stall), 32'd1);
        step(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rdata; #1;
        check({tag, " req_wait"}, 32'(data_req), 32'd0);
        check({tag, " stall_wait"}, 32'(mem_stall), 32'd1);
        step(); data_data_ok = 1'b0; #1;
        check({tag, " valid"}, 32'(mem_valid), 32'd1);
        check({tag, " rdata"}, mem_rdata, exp_rd);
        check({tag, " stall_done"}, 32'(mem_stall), 32'd0);
        step(); #1;
        check({tag, " valid_off"}, 32'(mem_valid), 32'd0);
    endtask

    // Zero-wait slave: addr_ok and data_ok together in the request cycle.
    task automatic lw_zero_wait(input string tag, input logic [31:0] addr, input logic [31:0] rdata);
        start(LW, addr, 32'h0); #1;
        check({tag, " stall_c0"}, 32'(mem_stall), 32'd1);
        step(); idle_inputs();
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = rdata; #1;
        check({tag, " req"}, 32'(data_req), 32'd1);
        step(); data_addr_ok = 1'b0; data_data_ok = 1'b0; #1;
        check({tag, " valid"}, 32'(mem_valid), 32'd1);
        check({tag, " rdata"}, mem_rdata, rdata);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; idle_inputs();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        step(); step(); #1;
        check("rst req", 32'(data_req), 32'd0);
        check("rst stall", 32'(mem_stall), 32'd0);
        check("rst valid", 32'(mem_valid), 32'd0);
        check("rst addr", data_addr, 32'h0);
        check("rst badvaddr", exc_badvaddr, 32'h0);
        rst = 1'b0;
        step();

        access("lw", LW, 32'h0000_1000, 32'h0, 0, 32'h8765_4321, 32'h8765_4321, 4'b0000, 32'h0, 2'd2, 1'b0);
        access("lb", LB, 32'h0000_1003, 32'h0, 0, 32'h8012_3456, 32'hffff_ff80, 4'b0000, 32'h0, 2'd0, 1'b0);
        access("lbu", LBU, 32'h0000_1003, 32'h0, 0, 32'h8012_3456, 32'h0000_0080, 4'b0000, 32'h0, 2'd0, 1'b0);
        access("lhu", LHU, 32'h0000_1002, 32'h0, 0, 32'hbeef_0000, 32'h0000_beef, 4'b0000, 32'h0, 2'd1, 1'b0);
        access("lh", LH, 32'h0000_1000, 32'h0, 1, 32'h1234_8001, 32'hffff_8001, 4'b0000, 32'h0, 2'd1, 1'b0);
        access("sb", SB, 32'h0000_2001, 32'h1234_56ab, 3, 32'hffff_ffff, 32'h0, 4'b0010, 32'habab_abab, 2'd0, 1'b1);
        access("sh", SH, 32'h0000_2002, 32'h0000_beef, 0, 32'hffff_ffff, 32'h0, 4'b1100, 32'hbeef_beef, 2'd1, 1'b1);
        access("sw", SW, 32'h0000_2004, 32'hcafe_f00d, 0, 32'hffff_ffff, 32'h0, 4'b1111, 32'hcafe_f00d, 2'd2, 1'b1);
        lw_zero_wait("lw0", 32'h0000_1100, 32'h0bad_f00d);

        // Misaligned load and store.
        start(LW, 32'h0000_1002, 32'h0); step(); idle_inputs(); #1;
        check("adel pulse", 32'(exc_adel), 32'd1);
        check("adel ades", 32'(exc_ades), 32'd0);
        check("adel badvaddr", exc_badvaddr, 32'h0000_1002);
        check("adel req", 32'(data_req), 32'd0);
        step(); #1;
        check("adel end", 32'(exc_adel), 32'd0);
        check("adel held", exc_badvaddr, 32'h0000_1002);
        start(SH, 32'h0000_0003, 32'h0); step(); idle_inputs(); #1;
        check("ades pulse", 32'(exc_ades), 32'd1);
        check("ades badvaddr", exc_badvaddr, 32'h0000_0003);
        check("ades req", 32'(data_req), 32'd0);
        step();

        // Non-memory opcode and flush in IDLE produce nothing.
        start(8'h21, 32'h0000_1000, 32'h0); #1;
        check("nonmem stall", 32'(mem_stall), 32'd0);
        step(); idle_inputs(); #1;
        check("nonmem req", 32'(data_req), 32'd0);
        start(LW, 32'h0000_1000, 32'h0); flush = 1'b1; #1;
        check("flush idle stall", 32'(mem_stall), 32'd0);
        step(); idle_inputs(); flush = 1'b0; #1;
        check("flush idle req", 32'(data_req), 32'd0);

        // Flush in WAIT: data_ok completes silently.
        start(LW, 32'h0000_1000, 32'h0); step(); idle_inputs();
        data_addr_ok = 1'b1; step(); data_addr_ok = 1'b0; flush = 1'b1;
        step(); flush = 1'b0; #1;
        check("flush wait stall", 32'(mem_stall), 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h1111_2222;
        step(); data_data_ok = 1'b0; #1;
        check("flush wait valid", 32'(mem_valid), 32'd0);
        step(); #1;
        check("flush wait valid2", 32'(mem_valid), 32'd0);
        lw_zero_wait("after_flush_wait", 32'h0000_1200, 32'h3333_4444);

        // Flush in REQ without addr_ok drops the request.
        start(LW, 32'h0000_1000, 32'h0); step(); idle_inputs(); flush = 1'b1; #1;
        check("flush req req", 32'(data_req), 32'd1);
        step(); flush = 1'b0; #1;
        check("flush req dropped", 32'(data_req), 32'd0);
        check("flush req stall", 32'(mem_stall), 32'd0);
        lw_zero_wait("after_flush_req", 32'h0000_1300, 32'h5555_6666);

        // Reset in WAIT aborts at once; the late data_ok is ignored.
        start(LW, 32'h0000_1000, 32'h0); step(); idle_inputs();
        data_addr_ok = 1'b1; step(); data_addr_ok = 1'b0; #1;
        rst = 1'b1; #1;
        check("rst wait stall", 32'(mem_stall), 32'd0);
        check("rst wait addr", data_addr, 32'h0);
        check("rst wait req", 32'(data_req), 32'd0);
        step(); rst = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h7777_8888;
        step(); data_data_ok = 1'b0; #1;
        check("rst late valid", 32'(mem_valid), 32'd0);
        step(); #1;
        check("rst late valid2", 32'(mem_valid), 32'd0);

`ifdef MEM_TIMEOUT_EN
        begin
            int cyc;
            bit seen;
            start(LW, 32'h0000_1000, 32'h0); step(); idle_inputs();
            data_addr_ok = 1'b1; step(); data_addr_ok = 1'b0;
            cyc = 0; seen = 1'b0;
            while (!seen && cyc < 20) begin
                #1;
                if (mem_valid) seen = 1'b1;
                else begin step(); cyc++; end
            end
            check("timeout seen", 32'(seen), 32'd1);
            check("timeout rdata", mem_rdata, 32'hdead_beef);
            step();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
